// File: rtl/uart_rx_fifo_if.sv
// Byte stream bundle between a UART receiver, the RX FIFO and a UART transmitter.
// Also carries the FIFO's status outputs and its overflow clear.
interface uart_rx_fifo_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
);
  logic [DATA_WIDTH-1:0]    in_data;
  logic                     in_valid;
  logic [DATA_WIDTH-1:0]    axis_tdata;
  logic                     axis_tvalid;
  logic                     axis_tready;
  logic [$clog2(DEPTH):0]   count;
  logic                     full;
  logic                     empty;
  logic                     overflow;
  logic                     clr_overflow;

  modport master (
    output in_data, in_valid, axis_tready, clr_overflow,
    input  axis_tdata, axis_tvalid, count, full, empty, overflow
  );

  modport slave (
    input  in_data, in_valid, axis_tready, clr_overflow,
    output axis_tdata, axis_tvalid, count, full, empty, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// RX byte FIFO: drops bytes when full and flags the loss with a sticky overflow bit.
// The AXI-Stream side shows the head entry one cycle after it is pushed.
module uart_rx_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_rx_fifo_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  full, empty, push, pop, drop;

  // Flags come from the registered count so a wrapped pointer pair is never ambiguous.
  assign full  = (count_q == DepthCnt);
  assign empty = (count_q == '0);
  assign pop   = !empty && bus.axis_tready;
  assign push  = bus.in_valid && (!full || pop);
  assign drop  = bus.in_valid && !push;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
    // A drop on the same edge as a clear keeps the flag set.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (bus.clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is left unreset; empty masks stale contents on the output.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_data;
  end

  assign bus.axis_tvalid = !empty;
  assign bus.axis_tdata  = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.count       = count_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_uart_rx_fifo;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   cmp_en = 1'b0;

  uart_rx_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue plus the sticky drop flag.
  logic [DW-1:0] mq [$];
  bit            m_ovf;
  bit            m_pop, m_push;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      m_pop  = (mq.size() > 0) && bus.axis_tready;
      m_push = bus.in_valid && ((mq.size() < DEPTH) || m_pop);
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(bus.in_data);
      if (bus.in_valid && !m_push) m_ovf = 1'b1;
      else if (bus.clr_overflow)   m_ovf = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_tvalid", 32'(bus.axis_tvalid), 32'(mq.size() != 0));
      chk("m_tdata",  32'(bus.axis_tdata),  (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
      chk("m_count",  32'(bus.count),       32'(mq.size()));
      chk("m_full",   32'(bus.full),        32'(mq.size() == DEPTH));
      chk("m_empty",  32'(bus.empty),       32'(mq.size() == 0));
      chk("m_ovf",    32'(bus.overflow),    32'(m_ovf));
    end
  end

  // Apply inputs for the coming rising edge, then return at the following falling edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic c);
    bus.in_valid     = v;
    bus.in_data      = d;
    bus.axis_tready  = r;
    bus.clr_overflow = c;
    @(negedge clk);
  endtask

  task automatic drain_all();
    for (int i = 0; i < 4 * DEPTH && mq.size() > 0; i++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  int rx_idx, tx_idx;
  bit tgl;
  int pv, pr;

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.axis_tready = 1'b0; bus.clr_overflow = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_tvalid", 32'(bus.axis_tvalid), 32'h0);
    chk("rst_empty",  32'(bus.empty),       32'h1);
    chk("rst_count",  32'(bus.count),       32'h0);
    rst_n = 1'b1;

    // Single byte, held stable, then popped.
    step(1'b1, 8'h41, 1'b0, 1'b0);
    chk("single_tvalid", 32'(bus.axis_tvalid), 32'h1);
    chk("single_tdata",  32'(bus.axis_tdata),  32'h41);
    chk("single_count",  32'(bus.count),       32'h1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("single_hold", 32'(bus.axis_tdata), 32'h41);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("single_empty", 32'(bus.empty),      32'h1);
    chk("single_zero",  32'(bus.axis_tdata), 32'h0);

    // Fill past capacity: 0x10 is dropped.
    for (int i = 0; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill_full",  32'(bus.full),     32'h1);
    chk("fill_count", 32'(bus.count),    32'd16);
    chk("fill_ovf",   32'(bus.overflow), 32'h1);
    for (int i = 0; i < 16; i++) begin
      chk("fill_order", 32'(bus.axis_tdata), 32'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("fill_drained", 32'(bus.empty), 32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("fill_ovf_clr", 32'(bus.overflow), 32'h0);

    // Push and pop together while full.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    chk("fullpp_count", 32'(bus.count),    32'd16);
    chk("fullpp_ovf",   32'(bus.overflow), 32'h0);
    chk("fullpp_head",  32'(bus.axis_tdata), 32'h21);
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fullpp_last", 32'(bus.axis_tdata), 32'hAA);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fullpp_empty", 32'(bus.empty), 32'h1);

    // Stream 100 bytes with tready toggling, throttling the producer to avoid drops.
    rx_idx = 0; tx_idx = 0; tgl = 1'b0;
    for (int c = 0; c < 1000 && rx_idx < 100; c++) begin
      tgl = ~tgl;
      if (tgl && mq.size() > 0) begin
        chk("wrap_order", 32'(bus.axis_tdata), 32'(rx_idx));
        rx_idx++;
      end
      if (tx_idx < 100 && mq.size() < DEPTH - 1) begin
        step(1'b1, 8'(tx_idx), tgl, 1'b0);
        tx_idx++;
      end else begin
        step(1'b0, 8'h00, tgl, 1'b0);
      end
    end
    chk("wrap_rx_cnt", 32'(rx_idx),    32'd100);
    chk("wrap_count",  32'(bus.count), 32'h0);
    chk("wrap_ovf",    32'(bus.overflow), 32'h0);

    // Drop coinciding with clear keeps overflow; a lone clear then clears it.
    for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    chk("prio_set", 32'(bus.overflow), 32'h1);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    chk("prio_set_wins", 32'(bus.overflow), 32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("prio_clr", 32'(bus.overflow), 32'h0);
    drain_all();

    // Asynchronous reset between edges with five entries stored and overflow set.
    for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    bus.axis_tready = 1'b0;
    chk("arst_pre_count", 32'(bus.count), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tvalid", 32'(bus.axis_tvalid), 32'h0);
    chk("arst_tdata",  32'(bus.axis_tdata),  32'h0);
    chk("arst_count",  32'(bus.count),       32'h0);
    chk("arst_empty",  32'(bus.empty),       32'h1);
    chk("arst_full",   32'(bus.full),        32'h0);
    chk("arst_ovf",    32'(bus.overflow),    32'h0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    chk("arst_push_data",  32'(bus.axis_tdata), 32'h55);
    chk("arst_push_count", 32'(bus.count),      32'h1);
    drain_all();

    // Randomized soak with shifting fill/drain bias.
    for (int seg = 0; seg < 8; seg++) begin
      pv = 20 + 10 * int'($urandom_range(7));
      pr = 20 + 10 * int'($urandom_range(7));
      for (int c = 0; c < 400; c++) begin
        step(1'($urandom_range(99) < pv), 8'($urandom), 1'($urandom_range(99) < pr),
             1'($urandom_range(9) == 0));
      end
    end

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 8, the byte width of each entry.
REQ-002 The block SHALL expose parameter DEPTH, default 16, the number of entries; DEPTH is a power of two and at least 2.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset is asynchronous and active-low.
REQ-005 Port in_data, input, DATA_WIDTH bits: received byte from the UART receiver.
REQ-006 Port in_valid, input, 1 bit: single-cycle qualifier for in_data; there is no backpressure to the producer.
REQ-007 Port axis_tdata, output, DATA_WIDTH bits: head-of-queue byte to the UART transmitter.
REQ-008 Port axis_tvalid, output, 1 bit: axis_tdata holds a valid byte.
REQ-009 Port axis_tready, input, 1 bit: the transmitter accepts the byte.
REQ-010 Port count, output, log2(DEPTH)+1 bits: number of stored entries.
REQ-011 Port full, output, 1 bit: count equals DEPTH.
REQ-012 Port empty, output, 1 bit: count equals 0.
REQ-013 Port overflow, output, 1 bit: sticky flag meaning at least one byte was dropped.
REQ-014 Port clr_overflow, input, 1 bit: synchronous clear for overflow.

Function
REQ-015 A push SHALL occur on a clk edge when in_valid=1 and either full=0 or a pop occurs on the same edge.
- The push writes in_data at wr_ptr.
- wr_ptr then advances modulo DEPTH.
REQ-016 A pop SHALL occur on a clk edge when axis_tvalid=1 and axis_tready=1; rd_ptr then advances modulo DEPTH.
REQ-017 axis_tvalid SHALL equal not empty.
REQ-018 axis_tdata SHALL equal the entry at rd_ptr while axis_tvalid=1, and SHALL be all-zero while axis_tvalid=0.
REQ-019 Latency SHALL be one cycle: a push into an empty FIFO at edge N gives axis_tvalid=1 with that byte after edge N.
REQ-020 While axis_tvalid=1 and axis_tready=0, axis_tdata and axis_tvalid SHALL hold stable.
REQ-021 count SHALL update on each edge as follows:
- +1 on push only.
- -1 on pop only.
- Unchanged on simultaneous push and pop, or on neither.
REQ-022 Simultaneous push and pop on an empty FIFO SHALL be impossible, because there is no pop when empty; the push proceeds normally.
REQ-023 A simultaneous push and pop on a full FIFO SHALL accept the new byte; count stays DEPTH and nothing is dropped.
REQ-024 When in_valid=1, full=1 and no pop occurs, the byte SHALL be discarded.
- Pointers and count stay unchanged.
- overflow is set to 1 on that edge.
REQ-025 overflow SHALL stay 1 until a clk edge with clr_overflow=1 and no new drop.
- If a drop and clr_overflow coincide, overflow stays 1 (set wins).
REQ-026 Bytes SHALL leave in arrival order with no duplication, across any number of pointer wrap-arounds.
REQ-027 full and empty SHALL be derived from the registered count, never from pointer comparison alone.

Reset
REQ-028 While rst_n=0, the block SHALL force the following:
- wr_ptr=0, rd_ptr=0, count=0.
- empty=1, full=0, axis_tvalid=0.
- axis_tdata=0, overflow=0.
- Entries are not required to be cleared.
REQ-029 Reset assertion SHALL take effect immediately, without a clk edge, and SHALL discard any in-flight byte mid-operation.
REQ-030 After rst_n deasserts, the first clk edge SHALL already accept a push.

Verification
REQ-031 Single byte: push 0x41 with axis_tready=0 -> next cycle axis_tvalid=1, axis_tdata=0x41, count=1; hold 5 cycles stable; tready=1 one cycle -> empty=1, axis_tdata=0x00.
REQ-032 Fill and overflow: push 0x00..0x10 (17 bytes) with tready=0 -> full=1, count=16, overflow=1; drain reads 0x00..0x0F in order, and 0x10 is absent.
REQ-033 Full with simultaneous push and pop: fill 16 entries, then push 0xAA with tready=1 -> count stays 16, overflow=0; 0xAA emerges last.
REQ-034 Wrap-around: stream 100 bytes 0x00..0x63 with tready toggling every cycle -> all received in order and count returns to 0.
REQ-035 Overflow clear priority: with overflow=1, assert clr_overflow together with a drop -> overflow=1; assert clr_overflow alone next cycle -> overflow=0.
REQ-036 Async reset: with count=5, pull rst_n low between clk edges -> outputs reach their reset values before the next edge; after release, a push of 0x55 appears with count=1.
